// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped UART.
// Register map, STATUS layout, I/O window and FSM encodings.
package io_pkg;

  localparam logic [2:0] IO_WIN = 3'b011;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_TXRDY = 0;
  localparam int ST_RXVAL = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_BUSY  = 4;
  localparam int ST_RXIE  = 7;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  // Divisors below 2 are clamped so the RX half-period stays non-zero.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/io_uart_rx.sv
// io_uart_rx: 8N1 receiver with 2-FF synchronizer.
// Emits a one-cycle strobe with the byte, or a frame_err pulse.
module io_uart_rx
  import io_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        rxd,
  input  logic [15:0] div_eff,
  output logic        rx_strobe,
  output logic        frame_err,
  output logic [7:0]  rx_data
);

  logic [1:0]  sync;
  logic        prev;
  logic        s;
  logic        tick;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  nbit;
  logic [7:0]  sr;

  assign s    = sync[1];
  assign tick = cnt == 16'd0;

  // Synchronize rxd, detect start, sample mid-bit and deliver.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync      <= 2'b11;
      prev      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      nbit      <= '0;
      sr        <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      sync      <= {sync[0], rxd};
      prev      <= s;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (prev && !s) begin
            state <= RX_START;
            cnt   <= div_eff >> 1;
          end
        end
        RX_START: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (s) begin
            state <= RX_IDLE;
          end else begin
            state <= RX_DATA;
            cnt   <= div_eff;
            nbit  <= '0;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            sr   <= {s, sr[7:1]};
            nbit <= nbit + 3'd1;
            cnt  <= div_eff;
            if (nbit == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            state <= RX_IDLE;
            if (s) begin
              rx_strobe <= 1'b1;
              rx_data   <= sr;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/io_uart.sv
// io_uart: CPU-bus UART in the $6000-$7FFF window.
// Bus decode, register file and 8N1 transmitter.
module io_uart
  import io_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  io_dout,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  logic        sel, rd, wr, pop;
  logic [1:0]  idx;
  logic [15:0] div, div_eff;
  logic [7:0]  thr, tsr, rbr, status;
  logic        thr_full, rx_valid, overrun, ferr, rxie;
  logic        tx_load, tx_tick;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  tx_state_t   tx_state;
  logic        rx_strobe, rx_ferr;
  logic [7:0]  rx_data;
  logic        unused_ad;

  assign sel       = AD[15:13] == IO_WIN;
  assign idx       = AD[1:0];
  assign rd        = sel & ~WE;
  assign wr        = sel & WE;
  assign pop       = rd & (idx == REG_DATA);
  assign unused_ad = ^AD[12:2];
  assign div_eff   = eff_div(div);
  assign tx_tick   = tx_cnt == 16'd0;
  assign tx_load   = thr_full & ((tx_state == TX_IDLE) |
                     ((tx_state == TX_STOP) & tx_tick));
  assign irq       = rx_valid & rxie;

  // Assemble the STATUS view.
  always_comb begin
    status           = '0;
    status[ST_TXRDY] = ~thr_full;
    status[ST_RXVAL] = rx_valid;
    status[ST_OVR]   = overrun;
    status[ST_FERR]  = ferr;
    status[ST_BUSY]  = tx_state != TX_IDLE;
    status[ST_RXIE]  = rxie;
  end

  io_uart_rx u_rx (
    .clk       (clk),
    .RST       (RST),
    .rxd       (rxd),
    .div_eff   (div_eff),
    .rx_strobe (rx_strobe),
    .frame_err (rx_ferr),
    .rx_data   (rx_data)
  );

  // Registered read data, one cycle after the access.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      io_dout <= '0;
    end else if (rd) begin
      unique case (idx)
        REG_DATA:   io_dout <= rbr;
        REG_STATUS: io_dout <= status;
        REG_DIV_LO: io_dout <= div[7:0];
        REG_DIV_HI: io_dout <= div[15:8];
      endcase
    end
  end

  // Divisor, interrupt enable and receive-side flags.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      div      <= DEFAULT_DIV;
      rxie     <= 1'b0;
      overrun  <= 1'b0;
      ferr     <= 1'b0;
      rx_valid <= 1'b0;
      rbr      <= '0;
    end else begin
      if (wr && idx == REG_DIV_LO) div[7:0]  <= DO;
      if (wr && idx == REG_DIV_HI) div[15:8] <= DO;
      if (wr && idx == REG_STATUS) begin
        rxie    <= DO[7];
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end
      if (rx_ferr) ferr <= 1'b1;
      if (rx_strobe) begin
        if (rx_valid && !pop) begin
          overrun <= 1'b1;
        end else begin
          rbr      <= rx_data;
          rx_valid <= 1'b1;
        end
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Holding register and transmit frame FSM.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      tx_state <= TX_IDLE;
      thr      <= '0;
      thr_full <= 1'b0;
      tsr      <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      if (wr && idx == REG_DATA && (!thr_full || tx_load)) begin
        thr      <= DO;
        thr_full <= 1'b1;
      end else if (tx_load) begin
        thr_full <= 1'b0;
      end
      if (tx_load) begin
        tx_state <= TX_START;
        tsr      <= thr;
        txd      <= 1'b0;
        tx_cnt   <= div_eff;
      end else if (tx_state != TX_IDLE) begin
        if (!tx_tick) begin
          tx_cnt <= tx_cnt - 16'd1;
        end else begin
          tx_cnt <= div_eff;
          unique case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              txd      <= tsr[0];
              tx_bit   <= '0;
            end
            TX_DATA: begin
              if (tx_bit == 3'd7) begin
                tx_state <= TX_STOP;
                txd      <= 1'b1;
              end else begin
                tsr    <= tsr >> 1;
                txd    <= tsr[1];
                tx_bit <= tx_bit + 3'd1;
              end
            end
            default: tx_state <= TX_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/io_uart.md
# io_uart

Memory-mapped UART that responds to CPU bus cycles in the external I/O window ($6000–$7FFF), acting as the I/O-side responder to the CPU's memory map. It decodes the CPU address/write strobe, exposes four byte registers, and returns read data one clock after the address, the same latency as the on-chip RAM/ROM, so the top-level data-in mux treats it as a third memory source. Serial side is 8N1, LSB first, with a programmable bit period.

## Interface

- `DEFAULT_DIV`, default 16'd433: reset value of the divisor; bit period = DIV+1 clocks (434 clocks = 115200 baud at 50 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `AD`  in  16  CPU address, valid in the access cycle.
- `WE`  in  1  CPU write strobe, active high, same cycle as `AD`.
- `DO`  in  8  CPU write data, same cycle as `WE`.
- `io_dout`  out  8  registered read data, valid the cycle after the access.
- `txd`  out  1  serial transmit, idle high.
- `rxd`  in  1  serial receive, asynchronous to `clk`.
- `irq`  out  1  level interrupt, active high.

## Operation

- Select: `sel` = (AD[15:13] == 3'b011). Register index = AD[1:0]; AD[12:2] are ignored, so the 4 registers alias throughout the window.
- Register 0 DATA:
  - Write: loads the TX holding register (THR) and sets `thr_full`. A write while `thr_full`=1 is dropped.
  - Read: returns RBR and clears `rx_valid` (pop).
- Register 1 STATUS:
  - Read bits: [0] tx_ready (= !thr_full), [1] rx_valid, [2] overrun, [3] frame_err, [4] tx_busy, [7] rxie, others 0.
  - Write: clears overrun and frame_err regardless of data; bit 7 writes rxie.
- Registers 2/3: DIV[7:0] / DIV[15:8], read/write. Values below 2 behave as 2.
- A new DIV value applies at the next bit-period reload. Changing DIV mid-frame is undefined on the wire but must not hang either FSM.
- TX FSM states:
  - IDLE → START when thr_full. THR moves to the shift register and thr_full clears.
  - START (txd=0, one period) → DATA (8 periods, LSB first) → STOP (txd=1, one period) → IDLE.
  - At STOP exit with thr_full=1, go directly to START (back-to-back frames, no idle gap). tx_busy = state≠IDLE.
- RX path:
  - `rxd` passes through a 2-FF synchronizer.
  - RX FSM states:
    - IDLE: waits for a synchronized falling edge.
    - START: waits DIV>>1 clocks, then samples. If the sample is 1, it is a false start and the FSM returns to IDLE.
    - DATA: 8 samples, one period apart.
    - STOP: one sample, then back to IDLE.
  - Stop sample = 1: the byte is delivered to RBR. Stop sample = 0: frame_err is set and the byte is discarded.
  - Delivery while rx_valid=1: the byte is discarded and overrun is set (sticky).
  - Pop and delivery in the same cycle: the new byte is stored, rx_valid stays 1, and overrun is unchanged.
- `irq` = rx_valid & rxie.
- Write to DATA and TX load of THR in the same cycle: the write is accepted and thr_full stays 1 with the new byte.
- Dummy CPU reads of DATA pop RX; firmware must not do read-modify-write on DATA.

## Timing

- Read: access in cycle N (sel & !WE) → io_dout updated at the N+1 edge. When not selected, io_dout holds its last value.
- Write: register effects are visible from the N+1 edge. A STATUS read in the cycle right after a DATA write shows tx_ready=0.
- TX: DATA write in cycle N → txd falls at edge N+2 (1 cycle for thr_full, 1 for the IDLE→START load). Frame = 10·(DIV+1) clocks.
- RX latency: rx_valid rises 1 clock after the mid-stop-bit sample.
- Reset (async assert, any state, including mid-frame): txd=1, io_dout=0, irq=0, DIV=DEFAULT_DIV. All flags, THR, RBR and rxie = 0. Both FSMs go to IDLE and the synchronizer is set to 1s.
- Reset deassert is synchronous-released by the top level; the block needs no internal release logic.

## Structure

- Shared package `io_pkg`:
  - register offsets (REG_DATA=0, REG_STATUS=1, REG_DIV_LO=2, REG_DIV_HI=3);
  - STATUS bit positions;
  - IO window constant (3'b011);
  - TX/RX state encodings.
- One sub-module `io_uart_rx` (synchronizer, RX FSM, bit counter, period counter). Output: one-cycle `rx_strobe` plus data and frame_err.
- Bus decode, registers and TX FSM live in `io_uart`.

## Test plan

- Reset then read STATUS (AD=$6001) → io_dout=8'h01 next cycle; DIV regs read 8'hB1/8'h01; txd=1.
- DIV=3. Write $A5 to $6000 → txd low at N+2, bits 1,0,1,0,0,1,0,1 at 4-clock spacing, stop high; frame = 40 clocks.
- DIV=3. Write two bytes back-to-back with a tx_ready poll → 80 contiguous clocks of framing with no idle gap.
- DIV=7. Drive $3C serially on rxd → rx_valid=1, irq=1 after setting rxie. Read $6000 → $3C, then rx_valid=0.
- Inject a 2-clock low glitch on rxd → no byte, no flags. Send $55 with stop=0 → frame_err=1, rx_valid=0. Write STATUS → flag cleared.
- Receive two bytes without popping → RBR keeps the first byte and overrun=1. Assert RST mid-TX frame → txd=1 immediately and all status bits 0.
